// File: rtl/ulpi_pkg.sv
// ---------------------------------------------------------------------------
// ulpi_pkg
// Shared types for the ULPI receive path: RxCmd layout, RxEvent encoding,
// output FIFO entry format, packetizer FSM states and the PID sanity check.
// ---------------------------------------------------------------------------
package ulpi_pkg;

  typedef enum logic [1:0] {
    RXEV_INACTIVE = 2'b00,
    RXEV_ACTIVE   = 2'b01,
    RXEV_HOSTDISC = 2'b10,
    RXEV_ERROR    = 2'b11
  } rxevent_e;

  // RxCmd byte as sent by the PHY, MSB first.
  typedef struct packed {
    logic       alt_int;
    logic       id;
    rxevent_e   rxevent;
    logic [1:0] vbus;
    logic [1:0] line_state;
  } rxcmd_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       err;
  } pkt_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_DROP   = 2'b10
  } rx_state_e;

  localparam logic [7:0] OVF_CNT_MAX = 8'hFF;

  // A USB PID carries its own check nibble: PID[3:0] is the complement of PID[7:4].
  function automatic logic pid_ok(input logic [7:0] pid);
    return pid[3:0] == ~pid[7:4];
  endfunction

endpackage

// File: rtl/ulpi_rx_fifo.sv
// ---------------------------------------------------------------------------
// ulpi_rx_fifo
// Synchronous first-word-fall-through FIFO of pkt_entry_t.
// Ports:
//   clk, reset   clock / synchronous active-high reset (pointers and count only)
//   push, wdata  write request and entry; ignored when full unless popping
//   pop          read request; ignored when empty
//   rdata        head entry (all zero while empty)
//   count        number of stored entries
//   full, empty  status flags
// ---------------------------------------------------------------------------
module ulpi_rx_fifo
  import ulpi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  pkt_entry_t                   wdata,
  input  logic                         pop,
  output pkt_entry_t                   rdata,
  output logic [$clog2(FIFO_DEPTH):0]  count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LP_FULL = (AW+1)'(FIFO_DEPTH);

  pkt_entry_t  r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == LP_FULL);
  assign w_do_pop  = pop && !empty;
  // A simultaneous pop frees the slot being written, so push is legal when full.
  assign w_do_push = push && (!full || w_do_pop);
  assign count     = r_count;
  assign rdata     = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ulpi_rx_packetizer.sv
// ---------------------------------------------------------------------------
// ulpi_rx_packetizer
// Frames ULPI receive bytes into USB packets (last marker + error flag),
// buffers them in an output FIFO and publishes decoded PHY line status.
// Optional feature macro: ULPI_RX_PID_CHECK_EN -- when defined, the first
// byte of each packet is PID-checked and a bad PID flags the packet in error.
// Ports:
//   clk, reset                      clock / synchronous active-high reset
//   rx_cmd, rx_cmd_valid            RxCmd byte strobe from ulpi_link
//   rx_data, rx_data_valid          received data byte strobe
//   rx_turn_end                     PHY released the bus (dir fell)
//   pkt_data/last/err/valid, pkt_ready   FWFT packet byte stream
//   line_state, vbus_state          latched RxCmd fields
//   rx_active, host_disconnect      decoded RxEvent status
//   overflow_cnt                    saturating count of overflowed packets
// ---------------------------------------------------------------------------
module ulpi_rx_packetizer
  import ulpi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_cmd,
  input  logic       rx_cmd_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  input  logic       rx_turn_end,
  output logic [7:0] pkt_data,
  output logic       pkt_last,
  output logic       pkt_err,
  output logic       pkt_valid,
  input  logic       pkt_ready,
  output logic [1:0] line_state,
  output logic [1:0] vbus_state,
  output logic       rx_active,
  output logic       host_disconnect,
  output logic [7:0] overflow_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LP_NEARFULL = (AW+1)'(FIFO_DEPTH - 1);

  rx_state_e  r_state, w_state_nxt;
  logic [7:0] r_hold;
  logic       r_hold_full, w_hold_full_nxt;
  logic       w_hold_load;
  logic       r_err_acc, w_err_acc_nxt;
  logic [7:0] r_ovf_cnt;
  logic       w_ovf_inc;
  logic [1:0] r_line_state, r_vbus_state;
  logic       r_rx_active, r_host_disc;
  logic       w_pid_bad;

  rxcmd_t     w_cmd;
  logic       w_cmd_vld, w_cmd_start, w_cmd_end, w_end, w_data_vld;
  logic       w_unused_cmd_bits;

  pkt_entry_t w_push_entry, w_head;
  logic       w_push, w_pop, w_full, w_empty, w_free_le1;
  logic [AW:0] w_count;

  assign w_cmd             = rxcmd_t'(rx_cmd);
  assign w_unused_cmd_bits = w_cmd.alt_int ^ w_cmd.id;
  // Data wins over a (protocol-illegal) coincident RxCmd.
  assign w_cmd_vld   = rx_cmd_valid && !rx_data_valid;
  assign w_cmd_start = w_cmd_vld && (w_cmd.rxevent == RXEV_ACTIVE || w_cmd.rxevent == RXEV_ERROR);
  assign w_cmd_end   = w_cmd_vld && (w_cmd.rxevent == RXEV_INACTIVE || w_cmd.rxevent == RXEV_HOSTDISC);
  assign w_end       = w_cmd_end || rx_turn_end;
  // The dir-fall cycle is a turnaround and carries no real byte, so end wins.
  assign w_data_vld  = rx_data_valid && !rx_turn_end;
  // Keep one slot free so the terminating entry always fits.
  assign w_free_le1  = (w_count >= LP_NEARFULL);
  assign w_pop       = pkt_valid && pkt_ready;

`ifdef ULPI_RX_PID_CHECK_EN
  logic r_pid_bad;
  always_ff @(posedge clk) begin
    if (reset || r_state == ST_IDLE) r_pid_bad <= 1'b0;
    else if (w_hold_load && !r_hold_full) r_pid_bad <= !pid_ok(rx_data);
  end
  assign w_pid_bad = r_pid_bad;
`else
  assign w_pid_bad = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_hold_full_nxt = r_hold_full;
    w_hold_load     = 1'b0;
    w_err_acc_nxt   = r_err_acc;
    w_push          = 1'b0;
    w_push_entry    = '{data: r_hold, last: 1'b0, err: 1'b0};
    w_ovf_inc       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_cmd_start) begin
          w_state_nxt     = ST_ACTIVE;
          w_err_acc_nxt   = (w_cmd.rxevent == RXEV_ERROR);
          w_hold_full_nxt = 1'b0;
        end
      end
      ST_ACTIVE: begin
        if (w_end) begin
          // An empty hold means a zero-byte packet: nothing is emitted.
          w_push            = r_hold_full;
          w_push_entry.last = 1'b1;
          w_push_entry.err  = r_err_acc || w_pid_bad;
          w_hold_full_nxt   = 1'b0;
          w_state_nxt       = ST_IDLE;
        end else if (w_data_vld) begin
          w_hold_load     = 1'b1;
          w_hold_full_nxt = 1'b1;
          if (r_hold_full) begin
            if (w_free_le1) w_state_nxt = ST_DROP;
            else            w_push      = 1'b1;
          end
        end else if (w_cmd_vld && w_cmd.rxevent == RXEV_ERROR) begin
          w_err_acc_nxt = 1'b1;
        end
      end
      ST_DROP: begin
        if (w_end) begin
          w_push            = 1'b1;
          w_push_entry.last = 1'b1;
          w_push_entry.err  = 1'b1;
          w_ovf_inc         = 1'b1;
          w_hold_full_nxt   = 1'b0;
          w_state_nxt       = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_hold_load) r_hold <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_hold_full  <= 1'b0;
      r_err_acc    <= 1'b0;
      r_ovf_cnt    <= '0;
      r_line_state <= '0;
      r_vbus_state <= '0;
      r_rx_active  <= 1'b0;
      r_host_disc  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_err_acc   <= w_err_acc_nxt;
      if (w_ovf_inc && r_ovf_cnt != OVF_CNT_MAX) r_ovf_cnt <= r_ovf_cnt + 8'd1;
      if (w_cmd_vld) begin
        r_line_state <= w_cmd.line_state;
        r_vbus_state <= w_cmd.vbus;
        r_host_disc  <= (w_cmd.rxevent == RXEV_HOSTDISC);
        r_rx_active  <= w_cmd_start;
      end
      if (rx_turn_end) r_rx_active <= 1'b0;
    end
  end

  ulpi_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .wdata (w_push_entry),
    .pop   (w_pop),
    .rdata (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign pkt_data        = w_head.data;
  assign pkt_last        = w_head.last;
  assign pkt_err         = w_head.err;
  assign pkt_valid       = !w_empty;
  assign line_state      = r_line_state;
  assign vbus_state      = r_vbus_state;
  assign rx_active       = r_rx_active;
  assign host_disconnect = r_host_disc;
  assign overflow_cnt    = r_ovf_cnt;

endmodule

// File: tb/tb_ulpi_rx_packetizer.sv
module tb_ulpi_rx_packetizer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_cmd = '0;
  logic       rx_cmd_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_data_valid = 1'b0;
  logic       rx_turn_end = 1'b0;
  logic [7:0] pkt_data;
  logic       pkt_last, pkt_err, pkt_valid;
  logic       pkt_ready = 1'b1;
  logic [1:0] line_state, vbus_state;
  logic       rx_active, host_disconnect;
  logic [7:0] overflow_cnt;

`ifdef ULPI_RX_PID_CHECK_EN
  localparam logic PID_ERR = 1'b1;
`else
  localparam logic PID_ERR = 1'b0;
`endif

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       e;
    logic       dc;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  ulpi_rx_packetizer #(.FIFO_DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .rx_cmd          (rx_cmd),
    .rx_cmd_valid    (rx_cmd_valid),
    .rx_data         (rx_data),
    .rx_data_valid   (rx_data_valid),
    .rx_turn_end     (rx_turn_end),
    .pkt_data        (pkt_data),
    .pkt_last        (pkt_last),
    .pkt_err         (pkt_err),
    .pkt_valid       (pkt_valid),
    .pkt_ready       (pkt_ready),
    .line_state      (line_state),
    .vbus_state      (vbus_state),
    .rx_active       (rx_active),
    .host_disconnect (host_disconnect),
    .overflow_cnt    (overflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Protocol guard on the stimulus itself.
  always @(posedge clk) begin
    assert (!(rx_cmd_valid && rx_data_valid));
  end

  // Scoreboard: every accepted head byte must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && pkt_valid && pkt_ready) begin
      check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        if (!e.dc) check("pkt_data", 32'(pkt_data), 32'(e.d));
        check("pkt_last", 32'(pkt_last), 32'(e.l));
        check("pkt_err", 32'(pkt_err), 32'(e.e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic l, input logic e, input logic dc);
    exp_t x;
    x.d = d; x.l = l; x.e = e; x.dc = dc;
    sb.push_back(x);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    rx_cmd = b; rx_cmd_valid = 1'b1;
    tick();
    rx_cmd_valid = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] b);
    rx_data = b; rx_data_valid = 1'b1;
    tick();
    rx_data_valid = 1'b0;
  endtask

  task automatic send_turn_end();
    rx_turn_end = 1'b1;
    tick();
    rx_turn_end = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((sb.size() != 0 || pkt_valid) && k < 60) begin
      tick();
      k++;
    end
    check({tag, "_drained"}, 32'(sb.size()), 32'd0);
    check({tag, "_fifo_empty"}, 32'(pkt_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] t4 [8];
    t4 = '{8'hE1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};

    // Reset state
    tick(); tick();
    check("rst_pkt_valid", 32'(pkt_valid), 32'd0);
    check("rst_pkt_data", 32'(pkt_data), 32'd0);
    check("rst_line_state", 32'(line_state), 32'd0);
    check("rst_vbus", 32'(vbus_state), 32'd0);
    check("rst_rx_active", 32'(rx_active), 32'd0);
    check("rst_host_disc", 32'(host_disconnect), 32'd0);
    check("rst_ovf", 32'(overflow_cnt), 32'd0);
    reset = 1'b0;
    tick();

    // 1: plain four-byte packet
    expect_byte(8'hC3, 1'b0, 1'b0, 1'b0);
    expect_byte(8'h01, 1'b0, 1'b0, 1'b0);
    expect_byte(8'h02, 1'b0, 1'b0, 1'b0);
    expect_byte(8'h03, 1'b1, 1'b0, 1'b0);
    send_cmd(8'h10);
    check("t1_rx_active_on", 32'(rx_active), 32'd1);
    send_data(8'hC3); send_data(8'h01); send_data(8'h02); send_data(8'h03);
    send_cmd(8'h00);
    check("t1_rx_active_off", 32'(rx_active), 32'd0);
    drain("t1");

    // 2: RxEvent error mid-packet, terminated by dir falling
    expect_byte(8'hC3, 1'b0, 1'b0, 1'b0);
    expect_byte(8'hAA, 1'b1, 1'b1, 1'b0);
    send_cmd(8'h10);
    send_data(8'hC3); send_data(8'hAA);
    send_cmd(8'h30);
    check("t2_rx_active_err", 32'(rx_active), 32'd1);
    send_turn_end();
    check("t2_rx_active_off", 32'(rx_active), 32'd0);
    drain("t2");

    // 3: zero-byte packet is discarded
    send_cmd(8'h10);
    send_cmd(8'h00);
    tick(); tick();
    check("t3_pkt_valid", 32'(pkt_valid), 32'd0);
    check("t3_ovf", 32'(overflow_cnt), 32'd0);

    // 4: overflow with the consumer stalled
    pkt_ready = 1'b0;
    expect_byte(8'hE1, 1'b0, 1'b0, 1'b0);
    expect_byte(8'h11, 1'b0, 1'b0, 1'b0);
    expect_byte(8'h22, 1'b0, 1'b0, 1'b0);
    expect_byte(8'h00, 1'b1, 1'b1, 1'b1);
    send_cmd(8'h10);
    for (int i = 0; i < 8; i++) send_data(t4[i]);
    send_cmd(8'h00);
    tick();
    check("t4_ovf", 32'(overflow_cnt), 32'd1);
    check("t4_head_valid", 32'(pkt_valid), 32'd1);
    check("t4_head_data", 32'(pkt_data), 32'hE1);
    pkt_ready = 1'b1;
    drain("t4");

    // 5: line status decode
    send_cmd(8'h05);
    check("t5_line_state", 32'(line_state), 32'd1);
    check("t5_vbus", 32'(vbus_state), 32'd1);
    check("t5_rx_active", 32'(rx_active), 32'd0);
    send_cmd(8'h20);
    check("t5_host_disc", 32'(host_disconnect), 32'd1);
    check("t5_rx_active2", 32'(rx_active), 32'd0);
    check("t5_line_state2", 32'(line_state), 32'd0);

    // 6: PID check on a single-byte packet
    expect_byte(8'hC4, 1'b1, PID_ERR, 1'b0);
    send_cmd(8'h10);
    check("t6_host_disc_clr", 32'(host_disconnect), 32'd0);
    send_data(8'hC4);
    send_cmd(8'h00);
    drain("t6");

    // 6b: reset in the middle of a packet flushes everything
    pkt_ready = 1'b0;
    send_cmd(8'h10);
    send_data(8'hE1); send_data(8'h34); send_data(8'h56);
    check("t6b_pre_valid", 32'(pkt_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6b_flush_valid", 32'(pkt_valid), 32'd0);
    check("t6b_ovf_clr", 32'(overflow_cnt), 32'd0);
    check("t6b_rx_active", 32'(rx_active), 32'd0);
    pkt_ready = 1'b1;
    send_turn_end();
    tick(); tick();
    check("t6b_no_tail", 32'(pkt_valid), 32'd0);
    check("t6b_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
